// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard issue bus.
// Decode drives the instruction fields and the flush request. The scoreboard
// returns the stall/fire decision, the per-register busy flags and the
// stall statistics.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int LAT_W  = 3,
  parameter int CNT_W  = 16
);

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rs;
  logic              issue_rs_used;
  logic [ADDR_W-1:0] issue_rt;
  logic              issue_rt_used;
  logic              issue_wr;
  logic [ADDR_W-1:0] issue_rd;
  logic [LAT_W-1:0]  issue_lat;
  logic              flush;
  logic              stall;
  logic              issue_fire;
  logic [NREG-1:0]   busy_vec;
  logic [CNT_W-1:0]  stall_cycles;

  // Decode side: presents instructions and observes the hazard decision.
  modport master (
    output issue_valid, issue_rs, issue_rs_used, issue_rt, issue_rt_used,
           issue_wr, issue_rd, issue_lat, flush,
    input  stall, issue_fire, busy_vec, stall_cycles
  );

  // Scoreboard side: consumes instructions and produces the decision.
  modport slave (
    input  issue_valid, issue_rs, issue_rs_used, issue_rt, issue_rt_used,
           issue_wr, issue_rd, issue_lat, flush,
    output stall, issue_fire, busy_vec, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Issue-stage RAW/WAW hazard scoreboard.
// Each architectural register has a small countdown. A nonzero count means a
// write to that register is still in flight. An issuing instruction stalls
// when any source it reads, or the destination it writes, is still in flight.
// Register 0 is hardwired: it is never loaded, so it never reports busy.
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int LAT_W  = 3,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           reset_n,
  hazard_scoreboard_if.slave sb
);

  localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Per-register latency countdown; entry 0 is held at zero by construction.
  logic [LAT_W-1:0]  r_cnt [NREG];
  logic [CNT_W-1:0]  r_stall_cycles;

  logic [NREG-1:0]   w_busy;
  logic              w_hz_a;
  logic              w_hz_b;
  logic              w_hz_w;
  logic              w_stall;
  logic              w_fire;
  logic              w_load;
  logic [LAT_W-1:0]  w_load_val;

  // A result that is ready "immediately" still occupies the register for
  // one cycle, so a latency of zero is promoted to one.
  function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
    logic [LAT_W-1:0] v;
    if (lat == LAT_ZERO) begin
      v = LAT_ONE;
    end else begin
      v = lat;
    end
    return v;
  endfunction

  // Busy flags come straight from the counters; register 0 is never busy.
  always_comb begin
    w_busy = {NREG{1'b0}};
    for (int i = 1; i < NREG; i++) begin
      w_busy[i] = (r_cnt[i] != LAT_ZERO);
    end
  end

  // Same-cycle hazard check and stall/fire decision for the presented
  // instruction. Reset and flush both suppress any decision.
  always_comb begin
    w_hz_a     = sb.issue_rs_used & w_busy[sb.issue_rs];
    w_hz_b     = sb.issue_rt_used & w_busy[sb.issue_rt];
    w_hz_w     = sb.issue_wr      & w_busy[sb.issue_rd];
    w_load_val = eff_lat(sb.issue_lat);
    if (reset_n && sb.issue_valid && !sb.flush) begin
      w_stall = w_hz_a | w_hz_b | w_hz_w;
      w_fire  = ~(w_hz_a | w_hz_b | w_hz_w);
    end else begin
      w_stall = 1'b0;
      w_fire  = 1'b0;
    end
    if (w_fire && sb.issue_wr && (sb.issue_rd != {ADDR_W{1'b0}})) begin
      w_load = 1'b1;
    end else begin
      w_load = 1'b0;
    end
  end

  // Counter update: flush clears everything, a fired write loads its
  // destination, and every other in-flight entry counts down by one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= LAT_ZERO;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (sb.flush) begin
          r_cnt[i] <= LAT_ZERO;
        end else if (w_load && (sb.issue_rd == ADDR_W'(i))) begin
          r_cnt[i] <= w_load_val;
        end else if (r_cnt[i] != LAT_ZERO) begin
          r_cnt[i] <= r_cnt[i] - LAT_ONE;
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  // Saturating count of stalled cycles; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign sb.stall        = w_stall;
  assign sb.issue_fire   = w_fire;
  assign sb.busy_vec     = w_busy;
  assign sb.stall_cycles = r_stall_cycles;

endmodule
